dds_voice_bank: RTL and testbench

- Parametrised multi-voice DDS core; successor to the fixed 4-voice, mux-selected DDS top level.
- Holds NVOICE independent phase accumulators, each with its own runtime-loadable tuning word and waveform select.
- Voice outputs are time-multiplexed round-robin onto one sample bus, with an optional frame mixer.
- Sits between the pin-level config decoder (upstream) and the DAC/output pin driver (downstream).

---
 rtl/dds_voice_bank_if.sv | 24 ++
 rtl/dds_voice_bank.sv | 167 ++++++++++++++++
 tb/tb_dds_voice_bank.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_voice_bank_if.sv
// Config write channel for dds_voice_bank: valid/ready handshake carrying one voice update.
interface dds_voice_bank_if #(
  parameter int unsigned NVOICE = 4,
  parameter int unsigned TW     = 16
);
  localparam int unsigned VW = $clog2(NVOICE);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [VW-1:0] cfg_voice;
  logic [TW-1:0] cfg_tune;
  logic [2:0]    cfg_wave;
  logic          cfg_phase_rst;

  modport master (
    output cfg_valid, cfg_voice, cfg_tune, cfg_wave, cfg_phase_rst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_voice, cfg_tune, cfg_wave, cfg_phase_rst,
    output cfg_ready
  );
endinterface

// File: rtl/dds_voice_bank.sv
// Multi-voice DDS: NVOICE phase accumulators, round-robin sample bus, two-state config FSM.
// Optional frame mixer enabled by defining DDS_MIX_EN.
module dds_voice_bank #(
  parameter int unsigned NVOICE = 4,
  parameter int unsigned TW     = 16,
  parameter int unsigned OW     = 12,
  localparam int unsigned VW    = $clog2(NVOICE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dds_voice_bank_if.slave       cfg,
  output logic [OW-1:0]         sample_out,
  output logic [VW-1:0]         sample_voice,
  output logic                  sample_valid,
  output logic [OW-1:0]         mix_out,
  output logic                  mix_valid
);

  typedef enum logic [0:0] {StIdle, StApply} state_e;

  state_e        state_q, state_d;
  logic          run_q;
  logic [VW-1:0] idx_q;

  logic [TW-1:0] phase_q [NVOICE];
  logic [TW-1:0] phase_d [NVOICE];
  logic [TW-1:0] tune_q  [NVOICE];
  logic [TW-1:0] tune_d  [NVOICE];
  logic [2:0]    wave_q  [NVOICE];
  logic [2:0]    wave_d  [NVOICE];

  logic [VW-1:0] lat_voice_q;
  logic [TW-1:0] lat_tune_q;
  logic [2:0]    lat_wave_q;
  logic          lat_prst_q;

  logic          accept;
  logic [OW-1:0] cur_wave;

  function automatic logic [OW-1:0] wave_fn(input logic [OW-1:0] p, input logic [2:0] sel);
    logic [OW-1:0] ramp;
    ramp = {p[OW-2:0], 1'b0};
    case (sel)
      3'd0:    return p;
      3'd1:    return ~p;
      3'd2:    return p[OW-1] ? '1 : '0;
      3'd3:    return p[OW-1] ? ~ramp : ramp;
      3'd4:    return (p[OW-1:OW-2] == 2'b00) ? '1 : '0;
      default: return '0;
    endcase
  endfunction

  // Config FSM; ready is held off until the first clock after reset release.
  always_comb begin
    state_d       = state_q;
    cfg.cfg_ready = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg.cfg_ready = run_q;
        if (cfg.cfg_valid && run_q) begin
          accept  = 1'b1;
          state_d = StApply;
        end
      end
      StApply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With power-of-two NVOICE every encodable voice index is in range, so no discard path is
  // needed; the apply simply addresses the latched voice.
  always_comb begin
    for (int v = 0; v < NVOICE; v++) begin
      phase_d[v] = phase_q[v] + tune_q[v];
      tune_d[v]  = tune_q[v];
      wave_d[v]  = wave_q[v];
    end
    if (state_q == StApply) begin
      tune_d[lat_voice_q] = lat_tune_q;
      wave_d[lat_voice_q] = lat_wave_q;
      if (lat_prst_q) phase_d[lat_voice_q] = '0;
    end
  end

  assign cur_wave = wave_fn(phase_q[idx_q][TW-1 -: OW], wave_q[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NVOICE; v++) begin
        phase_q[v] <= '0;
        tune_q[v]  <= '0;
        wave_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NVOICE; v++) begin
        phase_q[v] <= phase_d[v];
        tune_q[v]  <= tune_d[v];
        wave_q[v]  <= wave_d[v];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_voice_q <= '0;
      lat_tune_q  <= '0;
      lat_wave_q  <= '0;
      lat_prst_q  <= 1'b0;
    end else if (accept) begin
      lat_voice_q <= cfg.cfg_voice;
      lat_tune_q  <= cfg.cfg_tune;
      lat_wave_q  <= cfg.cfg_wave;
      lat_prst_q  <= cfg.cfg_phase_rst;
    end
  end

  // Sequencer samples pre-update voice state, so a voice written this cycle shows old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      idx_q        <= '0;
      sample_out   <= '0;
      sample_voice <= '0;
    end else begin
      run_q        <= 1'b1;
      idx_q        <= idx_q + VW'(1);
      sample_out   <= cur_wave;
      sample_voice <= idx_q;
    end
  end

  assign sample_valid = run_q;

`ifdef DDS_MIX_EN
  logic [OW+VW-1:0] acc_q;
  logic [OW+VW-1:0] acc_sum;
  logic             last_voice;

  assign acc_sum    = acc_q + (OW+VW)'(cur_wave);
  assign last_voice = (idx_q == VW'(NVOICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
    end else begin
      acc_q     <= (idx_q == '0) ? (OW+VW)'(cur_wave) : acc_sum;
      mix_valid <= last_voice;
      if (last_voice) mix_out <= OW'(acc_sum >> VW);
    end
  end
`else
  assign mix_out   = '0;
  assign mix_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dds_voice_bank.sv
// Scoreboard bench for dds_voice_bank: a cycle model pushes expected samples, a monitor pops them.
module tb_dds_voice_bank;
  localparam int unsigned NVOICE = 4;
  localparam int unsigned TW     = 16;
  localparam int unsigned OW     = 12;
  localparam int unsigned VW     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_voice_bank_if #(.NVOICE(NVOICE), .TW(TW)) cfg_bus ();

  logic [OW-1:0] sample_out;
  logic [VW-1:0] sample_voice;
  logic          sample_valid;
  logic [OW-1:0] mix_out;
  logic          mix_valid;

  dds_voice_bank #(.NVOICE(NVOICE), .TW(TW), .OW(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_bus.slave),
    .sample_out   (sample_out),
    .sample_voice (sample_voice),
    .sample_valid (sample_valid),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] wave_ref(input logic [OW-1:0] p, input logic [2:0] s);
    case (s)
      3'd0:    return p;
      3'd1:    return ~p;
      3'd2:    return p[OW-1] ? {OW{1'b1}} : {OW{1'b0}};
      3'd3:    return p[OW-1] ? ~{p[OW-2:0], 1'b0} : {p[OW-2:0], 1'b0};
      3'd4:    return (p[OW-1:OW-2] == 2'b00) ? {OW{1'b1}} : {OW{1'b0}};
      default: return '0;
    endcase
  endfunction

  // Reference model
  typedef struct packed {
    logic [VW-1:0] v;
    logic [OW-1:0] s;
  } exp_t;

  exp_t          q[$];
  logic [TW-1:0] m_phase [NVOICE];
  logic [TW-1:0] m_tune  [NVOICE];
  logic [2:0]    m_wave  [NVOICE];
  logic          m_apply, m_run;
  logic [VW-1:0] m_idx, m_lv;
  logic [TW-1:0] m_lt;
  logic [2:0]    m_lw;
  logic          m_lp;
  logic          m_rdy;

  assign m_rdy = m_run && !m_apply;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NVOICE; v++) begin
        m_phase[v] <= '0;
        m_tune[v]  <= '0;
        m_wave[v]  <= '0;
      end
      m_apply <= 1'b0;
      m_run   <= 1'b0;
      m_idx   <= '0;
      m_lv    <= '0;
      m_lt    <= '0;
      m_lw    <= '0;
      m_lp    <= 1'b0;
      q.delete();
    end else begin
      q.push_back({m_idx, wave_ref(m_phase[m_idx][TW-1 -: OW], m_wave[m_idx])});
      for (int v = 0; v < NVOICE; v++)
        m_phase[v] <= (m_apply && m_lp && int'(m_lv) == v) ? '0 : m_phase[v] + m_tune[v];
      if (m_apply) begin
        m_tune[m_lv] <= m_lt;
        m_wave[m_lv] <= m_lw;
      end
      if (m_rdy && cfg_bus.cfg_valid) begin
        m_apply <= 1'b1;
        m_lv    <= cfg_bus.cfg_voice;
        m_lt    <= cfg_bus.cfg_tune;
        m_lw    <= cfg_bus.cfg_wave;
        m_lp    <= cfg_bus.cfg_phase_rst;
      end else begin
        m_apply <= 1'b0;
      end
      m_idx <= m_idx + VW'(1);
      m_run <= 1'b1;
    end
  end

  // Monitor
  logic [OW+VW-1:0] msum = '0;
  exp_t             e;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cfg_ready", cfg_bus.cfg_ready, m_rdy);
      chk("sample_valid", sample_valid, m_run);
      if (sample_valid) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sample_voice", sample_voice, e.v);
          chk("sample_out", sample_out, e.s);
`ifdef DDS_MIX_EN
          msum <= (e.v == '0) ? (OW+VW)'(e.s) : msum + (OW+VW)'(e.s);
          if (e.v == VW'(NVOICE - 1)) begin
            chk("mix_valid", mix_valid, 1);
            chk("mix_out", mix_out, OW'((msum + (OW+VW)'(e.s)) >> VW));
          end else begin
            chk("mix_valid", mix_valid, 0);
          end
`else
          chk("mix_out_tied", mix_out, 0);
          chk("mix_valid_tied", mix_valid, 0);
`endif
        end
      end
    end
  end

  task automatic cfg_write(input logic [VW-1:0] v, input logic [TW-1:0] t,
                           input logic [2:0] w, input logic p);
    int n;
    @(negedge clk);
    cfg_bus.cfg_valid     = 1'b1;
    cfg_bus.cfg_voice     = v;
    cfg_bus.cfg_tune      = t;
    cfg_bus.cfg_wave      = w;
    cfg_bus.cfg_phase_rst = p;
    n = 0;
    while (!cfg_bus.cfg_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n == 16) chk("cfg_accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_voice(input logic [VW-1:0] v);
    int n;
    n = 0;
    while (sample_voice != v && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n == 16) chk("wait_voice_timeout", 32'd1, 32'd0);
  endtask

  task automatic phase0_wave(input logic [2:0] w, input logic [OW-1:0] exp);
    cfg_write(2'd2, 16'h0000, w, 1'b1);
    repeat (2) @(negedge clk);
    wait_voice(2'd2);
    chk("phase0_wave", sample_out, exp);
  endtask

  initial begin
    logic [7:0] pat;
    int         k;
    logic       rdy;
    cfg_bus.cfg_valid     = 1'b0;
    cfg_bus.cfg_voice     = '0;
    cfg_bus.cfg_tune      = '0;
    cfg_bus.cfg_wave      = '0;
    cfg_bus.cfg_phase_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_voice", sample_voice, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_cfg_ready", cfg_bus.cfg_ready, 0);
    chk("rst_mix_out", mix_out, 0);
    chk("rst_mix_valid", mix_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_voice", sample_voice, i);
      chk("idle_sample", sample_out, 0);
      chk("idle_valid", sample_valid, 1);
    end

    // Ready drops for exactly the APPLY cycle.
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_voice = 2'd1;
    cfg_bus.cfg_tune  = 16'h1000;
    cfg_bus.cfg_wave  = 3'd0;
    chk("ready_before_write", cfg_bus.cfg_ready, 1);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    chk("ready_in_apply", cfg_bus.cfg_ready, 0);
    @(negedge clk);
    chk("ready_after_apply", cfg_bus.cfg_ready, 1);
    repeat (70) @(negedge clk);

    cfg_write(2'd2, 16'h0800, 3'd3, 1'b0);
    repeat (70) @(negedge clk);
    cfg_write(2'd2, 16'h0800, 3'd2, 1'b0);
    repeat (40) @(negedge clk);

    // Back-to-back: valid held high for four writes.
    @(negedge clk);
    k = 0;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_voice = 2'd0;
    cfg_bus.cfg_tune  = 16'h0100;
    cfg_bus.cfg_wave  = 3'd0;
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      rdy    = cfg_bus.cfg_ready;
      pat[c] = rdy;
      @(negedge clk);
      if (rdy) begin
        k++;
        if (k == 4) begin
          cfg_bus.cfg_valid = 1'b0;
        end else begin
          cfg_bus.cfg_voice = VW'(k);
          cfg_bus.cfg_tune  = TW'(16'h0100 * (k + 1));
          cfg_bus.cfg_wave  = 3'(k + 1);
        end
      end
    end
    chk("b2b_accept_pattern", pat, 8'h55);
    chk("b2b_accept_count", k, 4);
    repeat (40) @(negedge clk);

    cfg_write(2'd0, 16'h1234, 3'd0, 1'b1);
    repeat (20) @(negedge clk);

    phase0_wave(3'd1, 12'hFFF);
    phase0_wave(3'd4, 12'hFFF);
    phase0_wave(3'd3, 12'h000);
    phase0_wave(3'd6, 12'h000);

    // Reset during APPLY discards the pending write.
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_voice = 2'd1;
    cfg_bus.cfg_tune  = 16'h2222;
    cfg_bus.cfg_wave  = 3'd1;
    chk("ready_before_abort", cfg_bus.cfg_ready, 1);
    @(negedge clk);
    cfg_bus.cfg_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sample_out", sample_out, 0);
    chk("abort_sample_voice", sample_voice, 0);
    chk("abort_sample_valid", sample_valid, 0);
    chk("abort_cfg_ready", cfg_bus.cfg_ready, 0);
    chk("abort_mix_valid", mix_valid, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_abort_sample", sample_out, 0);
    end
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
